// File: rtl/alu_mdu.sv
// alu_mdu: RV32I/RV64I base ALU plus iterative M-extension multiply/divide engines.
// Define ALU_MDU_EN to build the MUL/DIV engines; without it M ops return 0 in one cycle.
module alu_mdu #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic [2:0]      op_i,
  input  logic            op_qual_i,
  input  logic            op_ext_i,
  output logic [XLEN-1:0] out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_by_zero_o
);
  localparam int SHW = $clog2(XLEN);

  if ((XLEN != 32 && XLEN != 64) || (XLEN % MUL_STEP) != 0 ||
      (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4 && MUL_STEP != 8) ||
      (DIV_STEP != 1 && DIV_STEP != 2)) begin : g_bad_cfg
    $error("alu_mdu: unsupported parameter combination");
  end

  function automatic logic [XLEN-1:0] base_alu(input logic [2:0] f, input logic q,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (f)
      3'b000:  base_alu = q ? (a - b) : (a + b);
      3'b001:  base_alu = a << sh;
      3'b010:  base_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b011:  base_alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  base_alu = a ^ b;
      3'b101: begin
        // kept as separate assignments so the arithmetic shift stays signed
        if (q) base_alu = $signed(a) >>> sh;
        else   base_alu = a >> sh;
      end
      3'b110:  base_alu = a | b;
      3'b111:  base_alu = a & b;
      default: base_alu = '0;
    endcase
  endfunction

  logic [XLEN-1:0] out_q, out_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            accept_s;

`ifdef ALU_MDU_EN
  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int DIV_ITERS = XLEN / DIV_STEP;
  localparam int CW        = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_PREP = 3'd2,
    S_DIV      = 3'd3,
    S_FIX      = 3'd4
  } state_e;

  function automatic logic [2*XLEN-1:0] mul_iter(input logic [2*XLEN-1:0] acc,
                                                 input logic [2*XLEN-1:0] a,
                                                 input logic [MUL_STEP-1:0] bits);
    logic [2*XLEN-1:0] r;
    r = acc;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (bits[j]) r = r + (a << j);
      else         r = r;
    end
    return r;
  endfunction

  // {remainder, quotient/dividend} restoring step, DIV_STEP quotient bits at a time
  function automatic logic [2*XLEN-1:0] div_iter(input logic [2*XLEN-1:0] rq,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    r = {1'b0, rq[2*XLEN-1:XLEN]};
    q = rq[XLEN-1:0];
    for (int j = 0; j < DIV_STEP; j++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, d}) begin
        r    = r - {1'b0, d};
        q[0] = 1'b1;
      end else begin
        q[0] = 1'b0;
      end
    end
    return {r[XLEN-1:0], q};
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        f_q, f_d;
  logic [2*XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qn_q, qn_d, rn_q, rn_d;
  logic              mul_a_sgn_s, mul_b_sgn_s, div_sgn_s;
  logic [XLEN-1:0]   div_a_mag_s, div_b_mag_s, rem_s, quo_s;

  assign accept_s    = start_i && (state_q == S_IDLE);
  assign mul_a_sgn_s = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
  assign mul_b_sgn_s = (op_i[1:0] == 2'b01);
  assign div_sgn_s   = ~f_q[0];
  assign div_a_mag_s = (div_sgn_s && a_q[XLEN-1]) ? -a_q[XLEN-1:0] : a_q[XLEN-1:0];
  assign div_b_mag_s = (div_sgn_s && b_q[XLEN-1]) ? -b_q : b_q;
  assign rem_s       = acc_q[2*XLEN-1:XLEN];
  assign quo_s       = acc_q[XLEN-1:0];

  always_comb begin
    out_d   = out_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    state_d = state_q;
    f_d     = f_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qn_d    = qn_q;
    rn_d    = rn_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          f_d = op_i;
          b_d = in2_i;
          if (!op_ext_i) begin
            out_d  = base_alu(op_i, op_qual_i, in1_i, in2_i);
            done_d = 1'b1;
            dbz_d  = 1'b0;
          end else if (!op_i[2]) begin
            // a negative signed multiplier contributes -a * 2^XLEN up front
            a_d     = {{XLEN{in1_i[XLEN-1] & mul_a_sgn_s}}, in1_i};
            acc_d   = (mul_b_sgn_s && in2_i[XLEN-1]) ? ({(2*XLEN){1'b0}} - (a_d << XLEN))
                                                     : {(2*XLEN){1'b0}};
            cnt_d   = CW'(MUL_ITERS - 1);
            state_d = S_MUL;
          end else begin
            a_d     = {{XLEN{1'b0}}, in1_i};
            qn_d    = ~op_i[0] & (in1_i[XLEN-1] ^ in2_i[XLEN-1]);
            rn_d    = ~op_i[0] & in1_i[XLEN-1];
            cnt_d   = CW'(DIV_ITERS - 2);
            state_d = S_DIV_PREP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_iter(acc_q, a_q, b_q[MUL_STEP-1:0]);
        a_d   = a_q << MUL_STEP;
        b_d   = b_q >> MUL_STEP;
        if (cnt_q == '0) begin
          out_d   = (f_q == 3'b000) ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_PREP: begin
        // magnitudes are taken here and the first quotient step is folded in
        b_d     = div_b_mag_s;
        acc_d   = div_iter({{XLEN{1'b0}}, div_a_mag_s}, div_b_mag_s);
        state_d = S_DIV;
      end
      S_DIV: begin
        acc_d = div_iter(acc_q, b_q);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (b_q == '0) begin
          out_d = f_q[1] ? a_q[XLEN-1:0] : {XLEN{1'b1}};
          dbz_d = 1'b1;
        end else begin
          out_d = f_q[1] ? (rn_q ? -rem_s : rem_s) : (qn_q ? -quo_s : quo_s);
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      f_q     <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qn_q    <= 1'b0;
      rn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qn_q    <= qn_d;
      rn_q    <= rn_d;
    end
  end
`else
  assign accept_s = start_i;

  always_comb begin
    out_d  = out_q;
    done_d = 1'b0;
    dbz_d  = dbz_q;
    busy_d = 1'b0;
    if (accept_s) begin
      out_d  = op_ext_i ? {XLEN{1'b0}} : base_alu(op_i, op_qual_i, in1_i, in2_i);
      done_d = 1'b1;
      dbz_d  = 1'b0;
    end else begin
      out_d = out_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      out_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      busy_q <= busy_d;
    end
  end

  assign out_o         = out_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32, MUL_STEP=4, DIV_STEP=1); follows ALU_MDU_EN like the RTL.
module tb_alu_mdu;
  localparam int LAT_MUL = 32 / 4 + 1;
  localparam int LAT_DIV = 32 / 1 + 2;
`ifdef ALU_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i, start_i, op_qual_i, op_ext_i;
  logic [31:0] in1_i, in2_i, out_o;
  logic [2:0]  op_i;
  logic        busy_o, done_o, div_by_zero_o;
  int          errs = 0;
  int          checks = 0;

  alu_mdu #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(1)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .in1_i(in1_i), .in2_i(in2_i),
    .op_i(op_i), .op_qual_i(op_qual_i), .op_ext_i(op_ext_i), .out_o(out_o),
    .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Reference built from the ISA definition using plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic qual, input logic ext,
                                        input logic [31:0] a, input logic [31:0] b, output logic dz);
    longint          sp;
    longint unsigned up;
    logic [63:0]     w;
    int              ia, ib, sh;
    dz = 1'b0;
    ia = a;
    ib = b;
    sh = int'(b[4:0]);
    if (!ext) begin
      case (op)
        3'd0: return qual ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return (ia < ib) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: begin
          if (qual && a[31]) return (a >> sh) | ~(32'hFFFFFFFF >> sh);
          else return a >> sh;
        end
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    if (!MDU_ON) return 32'd0;
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = longint'(ia) * longint'(ib); w = sp; return w[63:32]; end
      3'd2: begin sp = longint'(ia) * longint'({32'd0, b}); w = sp; return w[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) begin dz = 1'b1; return 32'hFFFFFFFF; end
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) begin dz = 1'b1; return 32'hFFFFFFFF; end
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) begin dz = 1'b1; return a; end
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) begin dz = 1'b1; return a; end
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 8);
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic qual, input logic ext,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_v;
    logic        exp_dz;
    int          exp_lat, lat, nbusy;
    exp_v   = model(op, qual, ext, a, b, exp_dz);
    exp_lat = (ext && MDU_ON) ? (op[2] ? LAT_DIV : LAT_MUL) : 1;
    @(negedge clk);
    in1_i = a; in2_i = b; op_i = op; op_qual_i = qual; op_ext_i = ext; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; in1_i = $urandom; in2_i = $urandom; op_i = 3'($urandom);
    op_qual_i = 1'($urandom); op_ext_i = 1'($urandom);
    lat = 1; nbusy = 0;
    while (done_o !== 1'b1 && lat < 200) begin
      if (busy_o === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check(tag, "out", out_o, exp_v);
    check(tag, "dbz", div_by_zero_o, exp_dz);
    check(tag, "latency", lat, exp_lat);
    check(tag, "busy_cycles", nbusy, exp_lat - 1);
    check(tag, "busy_at_done", busy_o, 1'b0);
    @(posedge clk); #1;
    check(tag, "done_pulse", done_o, 1'b0);
    check(tag, "out_held", out_o, exp_v);
  endtask

  initial begin
    int ndone, first_lat;
    logic [31:0] last_out;
    reset_i = 1'b1; start_i = 1'b0; in1_i = '0; in2_i = '0;
    op_i = 3'd0; op_qual_i = 1'b0; op_ext_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "out", out_o, 32'd0);
    check("reset", "done", done_o, 1'b0);
    check("reset", "busy", busy_o, 1'b0);
    check("reset", "dbz", div_by_zero_o, 1'b0);
    @(negedge clk); reset_i = 1'b0;

    // back-to-back: second start lands in the done cycle of the first
    @(negedge clk);
    in1_i = 32'd5; in2_i = 32'd7; op_i = 3'd0; op_qual_i = 1'b0; op_ext_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    check("add", "done", done_o, 1'b1);
    check("add", "out", out_o, 32'h0000000C);
    in1_i = 32'd3; in2_i = 32'd5; op_qual_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("sub_in_done", "done", done_o, 1'b1);
    check("sub_in_done", "out", out_o, 32'hFFFFFFFE);

    do_op("sra", 3'd5, 1'b1, 1'b0, 32'h80000000, 32'd4);
    do_op("srl", 3'd5, 1'b0, 1'b0, 32'h80000000, 32'd4);
    do_op("slt", 3'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    do_op("sltu", 3'd3, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    do_op("sll", 3'd1, 1'b0, 1'b0, 32'h00000003, 32'd33);
    do_op("mul", 3'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulhu", 3'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulh", 3'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("mulhsu", 3'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("div", 3'd4, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    do_op("rem", 3'd6, 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
    do_op("div0", 3'd4, 1'b0, 1'b1, 32'd7, 32'd0);
    do_op("rem0", 3'd6, 1'b0, 1'b1, 32'd7, 32'd0);
    do_op("divu0", 3'd5, 1'b0, 1'b1, 32'h80000001, 32'd0);
    do_op("div_ovf", 3'd4, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    do_op("rem_ovf", 3'd6, 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);

    // start while busy: ignored when the engine runs, accepted otherwise
    @(negedge clk);
    in1_i = 32'hFFFFFFF9; in2_i = 32'd2; op_i = 3'd4; op_qual_i = 1'b0; op_ext_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first_lat = 0; last_out = '0;
    for (int i = 1; i <= 45; i++) begin
      if (done_o === 1'b1) begin
        ndone++;
        if (first_lat == 0) first_lat = i;
        last_out = out_o;
      end
      if (i == 5) begin
        start_i = 1'b1; in1_i = 32'd1; in2_i = 32'd1; op_i = 3'd0; op_ext_i = 1'b0;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("busy_ignore", "dones", ndone, MDU_ON ? 1 : 2);
    check("busy_ignore", "latency", first_lat, MDU_ON ? LAT_DIV : 1);
    check("busy_ignore", "out", last_out, MDU_ON ? 32'hFFFFFFFD : 32'd2);

    // reset during a divide aborts it without a completion
    @(negedge clk);
    in1_i = 32'd100; in2_i = 32'd3; op_i = 3'd5; op_qual_i = 1'b0; op_ext_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    check("abort", "out", out_o, 32'd0);
    check("abort", "busy", busy_o, 1'b0);
    check("abort", "done", done_o, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) ndone++;
    end
    check("abort", "late_done", ndone, 0);
    do_op("add_after_abort", 3'd0, 1'b0, 1'b0, 32'd5, 32'd7);

    for (int n = 0; n < 60; n++) begin
      do_op("rand", 3'($urandom), 1'($urandom), 1'($urandom), pick(), pick());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
